sd_spi_block_engine: RTL and testbench

SD_SPI_BLOCK_ENGINE -- requirements
Module: sd_spi_block_engine

---
 rtl/sd_pkg.sv | 51 +++++
 rtl/sd_spi_byte.sv | 64 ++++++
 rtl/sd_spi_block_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_sd_spi_block_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI block engine: FSM states, error codes,
// token and command constants, command-frame and CRC16 helpers.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_CMD,
        ST_R1,
        ST_RESP,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_TAIL
    } sd_state_e;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_TOKEN      = 2'd2;
    localparam logic [1:0] ERR_CRC        = 2'd3;

    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [5:0] CMD8       = 6'd8;
    localparam logic [5:0] CMD17      = 6'd17;

    // Byte i (0..5) of the 48-bit command frame.
    function automatic logic [7:0] cmd_byte(input logic [2:0] i, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [6:0] crc);
        case (i)
            3'd0:    return {2'b01, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            3'd5:    return {crc, 1'b1};
            default: return 8'hFF;
        endcase
    endfunction

    // CRC16-CCITT (poly 0x1021), one byte MSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// One full-duplex SPI mode-0 byte: SD_CLK generation, MSB-first shift, go/done handshake.
module sd_spi_byte #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    tx_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '1;
            sclk    <= 1'b0;
            mosi    <= 1'b1;
            rx_byte <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (go) begin
                    active  <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    mosi    <= tx_byte[7];
                    tx_sh   <= tx_byte[6:0];
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (!sclk) begin
                    rx_byte <= {rx_byte[6:0], miso};
                end else if (bit_cnt == 3'd7) begin
                    // last falling edge: byte complete, line returns high
                    active <= 1'b0;
                    done   <= 1'b1;
                    mosi   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    mosi    <= tx_sh[6];
                    tx_sh   <= {tx_sh[5:0], 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_block_engine.sv
// SD card SPI command/response/single-block-read sequencer built on sd_spi_byte.
// Optional: define SD_CRC16_CHECK_EN to verify the data block CRC16 (err_code 3 on mismatch).
module sd_spi_block_engine
    import sd_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int RESP_BYTES  = 5,
    parameter int BLOCK_BYTES = 512,
    parameter int NCR_MAX     = 8,
    parameter int TOKEN_MAX   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        resp_long,
    input  logic        data_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  response_flags,
    output logic [31:0] response_data,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        SD_CLK,
    input  logic        D0,
    output logic        D1,
    output logic        CS
);
    localparam int PMAX = (TOKEN_MAX > NCR_MAX) ? ((TOKEN_MAX > 8) ? TOKEN_MAX : 8)
                                                : ((NCR_MAX > 8) ? NCR_MAX : 8);
    localparam int PW = $clog2(PMAX + 1);
    localparam int BW = $clog2(BLOCK_BYTES + 1);
    localparam logic [PW-1:0] CMD_LAST  = PW'(5);
    localparam logic [PW-1:0] NCR_LAST  = PW'(NCR_MAX - 1);
    localparam logic [PW-1:0] TOK_LAST  = PW'(TOKEN_MAX - 1);
    localparam logic [PW-1:0] RESP_LAST = PW'(RESP_BYTES - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(BLOCK_BYTES - 1);

    sd_state_e      state, post_r1;
    logic           go, bdone;
    logic [7:0]     tx_byte, rx_byte;
    logic [5:0]     idx_q;
    logic [31:0]    arg_q;
    logic [6:0]     crc_q;
    logic           long_q, den_q;
    logic [PW-1:0]  cnt;
    logic [BW-1:0]  data_cnt;
`ifdef SD_CRC16_CHECK_EN
    logic [15:0]    crc_calc;
    logic [7:0]     crc_hi;
`endif

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .tx_byte (tx_byte),
        .miso    (D0),
        .sclk    (SD_CLK),
        .mosi    (D1),
        .rx_byte (rx_byte),
        .done    (bdone)
    );

    // R1 error bits 6..1 suppress the data phase; the caller reads the flags.
    assign post_r1 = (den_q && (((state == ST_R1) ? rx_byte[6:1] : response_flags[6:1]) == 6'd0))
                   ? ST_TOKEN : ST_TAIL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            CS             <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_code       <= ERR_NONE;
            response_flags <= 8'hFF;
            response_data  <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            go             <= 1'b0;
            tx_byte        <= 8'hFF;
            idx_q          <= '0;
            arg_q          <= '0;
            crc_q          <= '0;
            long_q         <= 1'b0;
            den_q          <= 1'b0;
            cnt            <= '0;
            data_cnt       <= '0;
`ifdef SD_CRC16_CHECK_EN
            crc_calc       <= '0;
            crc_hi         <= '0;
`endif
        end else begin
            go   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    idx_q    <= cmd_index;
                    arg_q    <= cmd_arg;
                    crc_q    <= cmd_crc;
                    long_q   <= resp_long;
                    den_q    <= data_en;
                    err_code <= ERR_NONE;
                    busy     <= 1'b1;
                    CS       <= 1'b0;
                    state    <= ST_PRE;
                    go       <= 1'b1;
                    tx_byte  <= 8'hFF;
                end
                ST_PRE: if (bdone) begin
                    state   <= ST_CMD;
                    cnt     <= '0;
                    go      <= 1'b1;
                    tx_byte <= cmd_byte(3'd0, idx_q, arg_q, crc_q);
                end
                ST_CMD: if (bdone) begin
                    go <= 1'b1;
                    if (cnt == CMD_LAST) begin
                        state   <= ST_R1;
                        cnt     <= '0;
                        tx_byte <= 8'hFF;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        tx_byte <= cmd_byte(cnt[2:0] + 3'd1, idx_q, arg_q, crc_q);
                    end
                end
                ST_R1: if (bdone) begin
                    go      <= 1'b1;
                    tx_byte <= 8'hFF;
                    cnt     <= '0;
                    if (!rx_byte[7]) begin
                        response_flags <= rx_byte;
                        if (long_q && RESP_BYTES > 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= post_r1;
                            CS    <= (post_r1 == ST_TAIL);
                        end
                    end else if (cnt == NCR_LAST) begin
                        err_code <= ERR_R1_TIMEOUT;
                        state    <= ST_TAIL;
                        CS       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: if (bdone) begin
                    go            <= 1'b1;
                    tx_byte       <= 8'hFF;
                    response_data <= {response_data[23:0], rx_byte};
                    if (cnt == RESP_LAST) begin
                        cnt   <= '0;
                        state <= post_r1;
                        CS    <= (post_r1 == ST_TAIL);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TOKEN: if (bdone) begin
                    go      <= 1'b1;
                    tx_byte <= 8'hFF;
                    if (rx_byte == DATA_TOKEN) begin
                        state    <= ST_DATA;
                        data_cnt <= '0;
`ifdef SD_CRC16_CHECK_EN
                        crc_calc <= '0;
`endif
                    end else if (rx_byte[7:4] == 4'h0 || cnt == TOK_LAST) begin
                        err_code <= ERR_TOKEN;
                        state    <= ST_TAIL;
                        CS       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    // next byte launches only on the handshake, so SD_CLK stays low under backpressure
                    if (bdone) begin
                        rd_data  <= rx_byte;
                        rd_valid <= 1'b1;
`ifdef SD_CRC16_CHECK_EN
                        crc_calc <= crc16_byte(crc_calc, rx_byte);
`endif
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        go       <= 1'b1;
                        tx_byte  <= 8'hFF;
                        if (data_cnt == DATA_LAST) begin
                            state <= ST_CRC;
                            cnt   <= '0;
                        end else begin
                            data_cnt <= data_cnt + 1'b1;
                        end
                    end
                end
                ST_CRC: if (bdone) begin
                    go      <= 1'b1;
                    tx_byte <= 8'hFF;
                    if (cnt[0]) begin
                        state <= ST_TAIL;
                        CS    <= 1'b1;
`ifdef SD_CRC16_CHECK_EN
                        if ({crc_hi, rx_byte} != crc_calc) err_code <= ERR_CRC;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef SD_CRC16_CHECK_EN
                        crc_hi <= rx_byte;
`endif
                    end
                end
                ST_TAIL: if (bdone) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_block_engine.sv
// Directed bench for sd_spi_block_engine with a byte-level SPI card model.
module tb_sd_spi_block_engine;
    import sd_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic        resp_long = 1'b0, data_en = 1'b0, rd_ready = 1'b1;
    logic        busy, done, rd_valid, SD_CLK, D0, D1, CS;
    logic [1:0]  err_code;
    logic [7:0]  response_flags, rd_data;
    logic [31:0] response_data;

    int checks = 0, errors = 0;
    int done_cnt = 0, hs_cnt = 0, hs_bad = 0, stall_viol = 0, cyc = 0;
    logic rdy_mode = 1'b0;

    // card model: D0 shifts on SD_CLK falling edges, MOSI captured on rising edges
    logic [7:0] card_q[$];
    logic [7:0] card_byte = 8'hFF;
    logic [2:0] card_bit = 3'd0;
    logic [7:0] mosi_sh = 8'hFF;
    int         mosi_n = 0;
    logic [7:0] mosi_log[$];

    assign D0 = card_byte[3'd7 - card_bit];

    sd_spi_block_engine dut (
        .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_crc(cmd_crc), .resp_long(resp_long), .data_en(data_en), .busy(busy), .done(done),
        .err_code(err_code), .response_flags(response_flags), .response_data(response_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .SD_CLK(SD_CLK),
        .D0(D0), .D1(D1), .CS(CS)
    );

    always #5 clk = ~clk;

    always @(negedge SD_CLK) if (reset) begin
        if (card_bit == 3'd7) begin
            card_bit  = 3'd0;
            card_byte = (card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
        end else begin
            card_bit = card_bit + 3'd1;
        end
    end

    always @(posedge SD_CLK) begin
        mosi_sh = {mosi_sh[6:0], D1};
        mosi_n++;
        if (mosi_n == 8) begin
            mosi_n = 0;
            mosi_log.push_back(mosi_sh);
        end
        if (rd_valid && !rd_ready) stall_viol++;
    end

    // rd_ready driver and handshake / done monitor
    initial forever begin
        @(negedge clk);
        cyc++;
        rd_ready = rdy_mode ? cyc[2] : 1'b1;
        if (rd_valid && rd_ready) begin
            if (rd_data !== hs_cnt[7:0]) hs_bad++;
            hs_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            logic fb;
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic card_reset();
        card_q.delete();
        mosi_log.delete();
        card_byte = 8'hFF;
        card_bit  = 3'd0;
        mosi_n    = 0;
    endtask

    task automatic push_ff(input int n);
        for (int i = 0; i < n; i++) card_q.push_back(8'hFF);
    endtask

    // PRE + CMD, R1 = 00 on 2nd poll, n_ff idle token polls, then tok; data + CRC if tok is FE
    task automatic load_read(input int n_ff, input logic [7:0] tok, input logic bad_crc);
        logic [15:0] c;
        c = 16'h0;
        card_reset();
        push_ff(7);
        card_q.push_back(8'h00);
        push_ff(n_ff);
        card_q.push_back(tok);
        if (tok == DATA_TOKEN) begin
            for (int i = 0; i < 512; i++) begin
                card_q.push_back(i[7:0]);
                c = crc16(c, i[7:0]);
            end
            card_q.push_back(c[15:8]);
            card_q.push_back(c[7:0] ^ {7'd0, bad_crc});
        end
    endtask

    task automatic start_cmd(input logic [5:0] i, input logic [31:0] a, input logic [6:0] c,
                             input logic l, input logic d);
        @(negedge clk);
        cmd_index = i; cmd_arg = a; cmd_crc = c; resp_long = l; data_en = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err_code, 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   d0;
        logic ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk({tag, "_done"}, ok, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_cs_high"}, CS, 1);
        repeat (4) @(posedge clk);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        @(negedge clk);
    endtask

    initial begin
        int   h0;
        logic ok;
        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs", CS, 1);
        chk("rst_d1", D1, 1);
        chk("rst_sclk", SD_CLK, 0);
        chk("rst_busy_done_valid", {busy, done, rd_valid}, 0);
        chk("rst_err", err_code, 0);
        chk("rst_flags", response_flags, 8'hFF);
        chk("rst_resp_rd", {response_data, rd_data}, 0);
        @(negedge clk);
        reset = 1'b1;

        // CMD0, R1 = 01 on 2nd poll
        card_reset();
        push_ff(7);
        card_q.push_back(8'h01);
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
        wait_done("cmd0", 3000);
        chk("cmd0_flags", response_flags, 8'h01);
        chk("cmd0_err", err_code, 0);
        chk("cmd0_mosi_n", mosi_log.size(), 10);
        chk("cmd0_frame", {mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5], mosi_log[6]},
            64'h0000_4000_0000_0095);
        chk("cmd0_idle_bytes", {mosi_log[0], mosi_log[7], mosi_log[8], mosi_log[9]}, 32'hFFFF_FFFF);

        // CMD8 long response; a stray start while busy must be ignored
        card_reset();
        push_ff(6);
        card_q.push_back(8'h01); card_q.push_back(8'h00); card_q.push_back(8'h00);
        card_q.push_back(8'h01); card_q.push_back(8'hAA);
        start_cmd(CMD8, 32'h0000_01AA, 7'h43, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        cmd_index = 6'd0; cmd_arg = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("cmd8", 3000);
        chk("cmd8_flags", response_flags, 8'h01);
        chk("cmd8_data", response_data, 32'h0000_01AA);
        chk("cmd8_frame", {mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5], mosi_log[6]},
            64'h0000_4800_0001_AA87);

        // CMD17 full block with 50% backpressure
        load_read(2, DATA_TOKEN, 1'b0);
        hs_cnt = 0; hs_bad = 0; stall_viol = 0; rdy_mode = 1'b1;
        start_cmd(CMD17, 32'h0, 7'h2A, 1'b0, 1'b1);
        wait_done("cmd17", 60000);
        rdy_mode = 1'b0;
        chk("cmd17_handshakes", hs_cnt, 512);
        chk("cmd17_order", hs_bad, 0);
        chk("cmd17_stall", stall_viol, 0);
        chk("cmd17_err", err_code, 0);
        chk("cmd17_flags", response_flags, 8'h00);
        chk("cmd17_rd_valid", rd_valid, 0);

        // card never answers
        card_reset();
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
        wait_done("noresp", 3000);
        chk("noresp_err", err_code, 1);
        chk("noresp_bytes", mosi_log.size(), 16);

        // error token
        load_read(1, 8'h08, 1'b0);
        h0 = hs_cnt;
        start_cmd(CMD17, 32'h0, 7'h2A, 1'b0, 1'b1);
        wait_done("errtok", 3000);
        chk("errtok_err", err_code, 2);
        chk("errtok_no_data", hs_cnt - h0, 0);

        // R1 error bit with data_en: data phase skipped, no error code
        card_reset();
        push_ff(6);
        card_q.push_back(8'h04);
        start_cmd(CMD17, 32'h0, 7'h2A, 1'b0, 1'b1);
        wait_done("r1err", 3000);
        chk("r1err_flags", response_flags, 8'h04);
        chk("r1err_err", err_code, 0);
        chk("r1err_bytes", mosi_log.size(), 9);

`ifdef SD_CRC16_CHECK_EN
        load_read(0, DATA_TOKEN, 1'b1);
        start_cmd(CMD17, 32'h0, 7'h2A, 1'b0, 1'b1);
        wait_done("badcrc", 30000);
        chk("badcrc_err", err_code, 3);
`endif

        // reset during data byte 100
        load_read(0, DATA_TOKEN, 1'b0);
        hs_cnt = 0;
        start_cmd(CMD17, 32'h0, 7'h2A, 1'b0, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk);
            if (hs_cnt >= 100) begin ok = 1'b1; break; end
        end
        chk("abort_reach_100", ok, 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_cs", CS, 1);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sclk", SD_CLK, 0);
        repeat (3) @(negedge clk);
        card_reset();
        reset = 1'b1;
        push_ff(7);
        card_q.push_back(8'h01);
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
        wait_done("after_abort", 3000);
        chk("after_abort_flags", response_flags, 8'h01);
        chk("after_abort_err", err_code, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
